// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the RV32I fetch stage.
// Holds the fetch PC, computes the sequential successor, arbitrates
// trap / redirect / halt / stall requests and presents the PC to
// instruction memory through a valid/ready handshake. All outputs except
// pc_plus_o are registered; there is no combinational input-to-pc_o path.
//
// Handshake: pc_o is a fetch request whenever pc_valid_o=1. The request is
// consumed only at a rising edge where pc_valid_o=1 and imem_ready_i=1.
// While pc_valid_o=1 and imem_ready_i=0, pc_o is held stable unless a trap
// or redirect replaces it; the dropped request is not replayed.

module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00010000,
  parameter int unsigned     IALIGN       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            imem_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o,
  output logic [1:0]      state_o
);

  // Number of PC low bits that must be zero for an aligned address.
  localparam int unsigned     ALIGN_BITS = (IALIGN == 2) ? 1 : 2;
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN - ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};
  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            misalign_q;
  logic [XLEN-1:0] misalign_addr_q;

  logic [XLEN-1:0] trap_target;
  logic            target_misaligned;
  logic            fetch_advance;

  // Trap vectors are forced onto an instruction boundary rather than rejected.
  assign trap_target       = trap_vector_i & ALIGN_MASK;
  assign target_misaligned = |redirect_target_i[ALIGN_BITS-1:0];
  // Sequential advance needs no stall and an accepted fetch (valid is always 1 in RUN).
  assign fetch_advance     = !stall_i && !(pc_valid_q && !imem_ready_i);

  // Sequencer FSM: next PC, request valid, state and misalign reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_VECTOR;
      pc_valid_q      <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      // misalign_o is a single-cycle pulse; only the fault branch raises it.
      misalign_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
          if (trap_valid_i) begin
            pc_q <= trap_target;
          end
        end
        ST_RUN: begin
          if (trap_valid_i) begin
            pc_q       <= trap_target;
            pc_valid_q <= 1'b1;
          end else if (redirect_valid_i && !target_misaligned) begin
            pc_q       <= redirect_target_i;
            pc_valid_q <= 1'b1;
          end else if (redirect_valid_i) begin
            misalign_q      <= 1'b1;
            misalign_addr_q <= redirect_target_i;
            pc_valid_q      <= 1'b0;
            state_q         <= ST_FAULT;
          end else if (halt_i) begin
            pc_valid_q <= 1'b0;
            state_q    <= ST_HALT;
          end else if (fetch_advance) begin
            pc_q <= pc_q + STEP;
          end
        end
        ST_HALT: begin
          if (trap_valid_i) begin
            pc_q       <= trap_target;
            pc_valid_q <= 1'b1;
            state_q    <= ST_RUN;
          end else if (resume_i && !halt_i) begin
            pc_valid_q <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        ST_FAULT: begin
          if (trap_valid_i) begin
            pc_q       <= trap_target;
            pc_valid_q <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o            = pc_q;
  assign pc_valid_o      = pc_valid_q;
  assign pc_plus_o       = pc_q + STEP;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer. Two instances
// (IALIGN=4 and IALIGN=2) share identical stimulus; a reference model per
// instance pushes the expected post-edge outputs, and a monitor pops and
// compares them one time unit after every rising edge.

module tb_pc_sequencer;

  localparam int W = 100;
  localparam logic [31:0] RV = 32'h00010000;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        rst, stall_i, redirect_valid_i, trap_valid_i, halt_i, resume_i, imem_ready_i;
  logic [31:0] redirect_target_i, trap_vector_i;

  logic [31:0] pc4, pcp4, maddr4, pc2, pcp2, maddr2;
  logic        v4, mis4, v2, mis2;
  logic [1:0]  st4, st2;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(4)) dut4 (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
    .halt_i(halt_i), .resume_i(resume_i), .imem_ready_i(imem_ready_i),
    .pc_o(pc4), .pc_valid_o(v4), .pc_plus_o(pcp4),
    .misalign_o(mis4), .misalign_addr_o(maddr4), .state_o(st4)
  );

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(2)) dut2 (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .trap_valid_i(trap_valid_i), .trap_vector_i(trap_vector_i),
    .halt_i(halt_i), .resume_i(resume_i), .imem_ready_i(imem_ready_i),
    .pc_o(pc2), .pc_valid_o(v2), .pc_plus_o(pcp2),
    .misalign_o(mis2), .misalign_addr_o(maddr2), .state_o(st2)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          rst, stall, rv, tv, halt, resume, ready;
    logic [31:0] rt, tvec;
  } in_t;

  // Mode names as numbers: 0 boot, 1 run, 2 halt, 3 fault.
  typedef struct {
    int          mode;
    logic [31:0] pc;
    bit          valid;
    bit          mis;
    logic [31:0] maddr;
  } model_t;

  model_t m4, m2;
  logic [W-1:0] exp_q4[$];
  logic [W-1:0] exp_q2[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [31:0] round_down(logic [31:0] a, int ia);
    return a - (a % 32'(ia));
  endfunction

  function automatic model_t model_next(model_t m, in_t s, int ia);
    model_t n;
    n = m;
    n.mis = 1'b0;
    if (s.rst) begin
      n.mode = 0; n.pc = RV; n.valid = 1'b0; n.maddr = '0;
      return n;
    end
    if (m.mode == 0) begin
      n.mode = 1; n.valid = 1'b1;
      if (s.tv) n.pc = round_down(s.tvec, ia);
    end else if (m.mode == 1) begin
      if (s.tv) n.pc = round_down(s.tvec, ia);
      else if (s.rv && (s.rt % 32'(ia)) == 0) n.pc = s.rt;
      else if (s.rv) begin
        n.mis = 1'b1; n.maddr = s.rt; n.valid = 1'b0; n.mode = 3;
      end else if (s.halt) begin
        n.valid = 1'b0; n.mode = 2;
      end else if (!s.stall && s.ready) n.pc = m.pc + 32'(ia);
    end else begin
      // Halt and fault both leave on a trap; only halt also leaves on resume.
      if (s.tv) begin
        n.pc = round_down(s.tvec, ia); n.valid = 1'b1; n.mode = 1;
      end else if (m.mode == 2 && s.resume && !s.halt) begin
        n.valid = 1'b1; n.mode = 1;
      end
    end
    return n;
  endfunction

  function automatic logic [W-1:0] pack_exp(model_t m, int ia);
    logic [1:0] st;
    st = 2'(m.mode);
    return {st, m.valid, m.mis, m.pc, m.maddr, m.pc + 32'(ia)};
  endfunction

  // ---------------- driver tasks ----------------
  function automatic in_t idle();
    in_t s;
    s = '{default: 0};
    s.ready = 1'b1;
    return s;
  endfunction

  task automatic drive(input in_t s);
    @(negedge clk);
    rst = s.rst; stall_i = s.stall; redirect_valid_i = s.rv; redirect_target_i = s.rt;
    trap_valid_i = s.tv; trap_vector_i = s.tvec; halt_i = s.halt; resume_i = s.resume;
    imem_ready_i = s.ready;
    m4 = model_next(m4, s, 4);
    m2 = model_next(m2, s, 2);
    exp_q4.push_back(pack_exp(m4, 4));
    exp_q2.push_back(pack_exp(m2, 2));
  endtask

  task automatic drive_n(input in_t s, input int n);
    for (int i = 0; i < n; i++) drive(s);
  endtask

  function automatic in_t rand_in();
    in_t s;
    s = idle();
    s.rst    = ($urandom_range(0, 59) == 0);
    s.tv     = ($urandom_range(0, 11) == 0);
    s.tvec   = $urandom;
    s.rv     = ($urandom_range(0, 5) == 0);
    case ($urandom_range(0, 3))
      0: s.rt = $urandom;
      1: s.rt = $urandom & 32'hFFFF_FFFC;
      2: s.rt = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
      default: s.rt = ($urandom & 32'hFFFF_FFFC) | 32'h2;
    endcase
    s.halt   = ($urandom_range(0, 14) == 0);
    s.resume = ($urandom_range(0, 3) == 0);
    s.stall  = ($urandom_range(0, 4) == 0);
    s.ready  = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Pops one expectation per instance after each rising edge.
  always @(posedge clk) begin
    logic [W-1:0] e, a;
    #1;
    cyc++;
    if (exp_q4.size() > 0) begin
      e = exp_q4.pop_front();
      a = {st4, v4, mis4, pc4, maddr4, pcp4};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ialign4_outputs cycle %0d: got %h expected %h (state,valid,mis,pc,maddr,pc_plus)", cyc, a, e);
      end
    end
    if (exp_q2.size() > 0) begin
      e = exp_q2.pop_front();
      a = {st2, v2, mis2, pc2, maddr2, pcp2};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ialign2_outputs cycle %0d: got %h expected %h (state,valid,mis,pc,maddr,pc_plus)", cyc, a, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_t s;
    m4 = '{mode: 0, pc: RV, valid: 1'b0, mis: 1'b0, maddr: '0};
    m2 = m4;
    rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = '0;
    trap_valid_i = 1'b0; trap_vector_i = '0; halt_i = 1'b0; resume_i = 1'b0;
    imem_ready_i = 1'b1;

    // Reset, then free-run: BOOT, then 0x10000, 0x10004, 0x10008.
    s = idle(); s.rst = 1'b1; drive(s);
    drive_n(idle(), 3);
    // Memory back-pressure for three cycles, stall on the middle one.
    s = idle(); s.ready = 1'b0; drive(s);
    s.stall = 1'b1; drive(s);
    s.stall = 1'b0; drive(s);
    drive_n(idle(), 2);
    // Trap and redirect together: trap wins with low bits cleared.
    s = idle(); s.rv = 1'b1; s.rt = 32'h00010100; s.tv = 1'b1; s.tvec = 32'h00020003; drive(s);
    drive(idle());
    // Half-word target: fault on IALIGN=4, accepted on IALIGN=2.
    s = idle(); s.rv = 1'b1; s.rt = 32'h00010102; drive(s);
    drive_n(idle(), 2);
    s = idle(); s.halt = 1'b1; s.resume = 1'b1; s.rv = 1'b1; s.rt = 32'h00050000; drive(s);
    s = idle(); s.tv = 1'b1; s.tvec = 32'h00030000; drive(s);
    // Halt at 0x10020, ignored redirect, halt+resume stays, resume returns.
    s = idle(); s.rv = 1'b1; s.rt = 32'h00010020; drive(s);
    s = idle(); s.halt = 1'b1; drive(s);
    s = idle(); s.rv = 1'b1; s.rt = 32'h00040000; s.stall = 1'b1; drive(s);
    s = idle(); s.halt = 1'b1; s.resume = 1'b1; drive(s);
    s = idle(); s.resume = 1'b1; drive(s);
    drive(idle());
    // Reset during a stalled, un-acknowledged fetch.
    s = idle(); s.ready = 1'b0; s.stall = 1'b1; drive(s);
    s.rst = 1'b1; drive(s);
    // Trap taken in BOOT.
    s = idle(); s.tv = 1'b1; s.tvec = 32'h00060006; drive(s);
    drive(idle());
    // Wrap-around at the top of the address space.
    s = idle(); s.rv = 1'b1; s.rt = 32'hFFFF_FFFC; drive(s);
    drive_n(idle(), 3);
    // Redirect overrides a stalled fetch.
    s = idle(); s.ready = 1'b0; s.stall = 1'b1; s.rv = 1'b1; s.rt = 32'h00070000; drive(s);
    drive(idle());

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) drive(rand_in());
    drive(idle());

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the RV32I core, replacing the plain PC buffer register. It holds the fetch PC and computes the next sequential address internally. It arbitrates trap, branch/jump redirect, stall and halt requests, and runs a valid/ready handshake to instruction memory. It sits between the execute/trap logic and the instruction-memory address port.

Parameters:
XLEN, 32, PC width in bits.
RESET_VECTOR, 32'h00010000, PC value loaded on reset (program start address).
IALIGN, 4, instruction alignment in bytes (2 or 4); also the sequential increment.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  pipeline stall; blocks sequential advance only
redirect_valid_i  input  1  branch/jump taken this cycle
redirect_target_i  input  XLEN  branch/jump target address
trap_valid_i  input  1  trap/exception entry request
trap_vector_i  input  XLEN  trap handler address; low log2(IALIGN) bits ignored
halt_i  input  1  request to halt fetch
resume_i  input  1  request to leave HALT
imem_ready_i  input  1  instruction memory accepted pc_o this cycle
pc_o  output  XLEN  current fetch address
pc_valid_o  output  1  pc_o is a valid fetch request
pc_plus_o  output  XLEN  pc_o + IALIGN, modulo 2^XLEN (combinational)
misalign_o  output  1  one-cycle pulse: misaligned redirect rejected
misalign_addr_o  output  XLEN  offending target, held until the next misalign event or reset
state_o  output  2  FSM state: 0 BOOT, 1 RUN, 2 HALT, 3 FAULT

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-handshake):
  - pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0, misalign_addr_o=0, state=BOOT.
  - All other inputs are ignored that cycle.
- BOOT:
  - Lasts exactly one cycle, then moves to RUN with pc_valid_o=1 and pc_o=RESET_VECTOR.
  - trap_valid_i in BOOT is honoured: load the trap vector, go to RUN.
- RUN, next-PC priority evaluated each edge (highest first):
  1. trap_valid_i: pc <= trap_vector_i with low bits zeroed; state stays RUN.
  2. redirect_valid_i with aligned target: pc <= redirect_target_i.
  3. redirect_valid_i with misaligned target (target mod IALIGN != 0):
     - pc holds; misalign_o=1 for one cycle; misalign_addr_o <= target.
     - pc_valid_o=0; state <= FAULT.
  4. halt_i: pc holds; pc_valid_o <= 0; state <= HALT.
  5. stall_i=1, or imem_ready_i=0 with pc_valid_o=1: pc holds.
  6. Otherwise: pc <= pc_o + IALIGN, wrapping at 2^XLEN.
- Redirect and trap override stall_i and a pending un-acknowledged fetch. The dropped fetch is not replayed.
- A fetch is consumed only when pc_valid_o=1 and imem_ready_i=1 at the same edge.
- pc_o must stay stable while pc_valid_o=1 and imem_ready_i=0, unless a trap or redirect occurs.
- HALT:
  - pc_valid_o=0; pc holds; redirect_valid_i and stall_i are ignored.
  - trap_valid_i: load the trap vector, go to RUN.
  - Otherwise resume_i: go to RUN with the held pc.
  - halt_i and resume_i both high: stay in HALT.
- FAULT:
  - pc_valid_o=0; pc holds; only trap_valid_i (go to RUN with the vector) or rst leave this state.
  - halt_i, resume_i and redirect_valid_i are ignored.
- Latency: a request sampled at edge N is visible on pc_o/pc_valid_o after edge N. No combinational path from any input to pc_o.
- pc_plus_o = pc_o + IALIGN, truncated to XLEN bits. Example: 32'hFFFFFFFC gives 32'h00000000.
- IALIGN=2: the check uses bit 0 only, and the increment is 2.

Test Plan:
1. Reset, then free-run with imem_ready_i=1 -> BOOT for 1 cycle with pc_valid_o=0; then pc_o=0x10000, 0x10004, 0x10008 on consecutive cycles.
2. At pc 0x10008, set imem_ready_i=0 for 3 cycles, with stall_i=1 on cycle 2 -> pc_o holds 0x10008 for all 3 cycles, then advances to 0x1000C.
3. At pc 0x10010, assert redirect to 0x10100 together with trap to 0x20003 -> pc_o=0x20000 (trap wins, low bits zeroed); the redirect is discarded.
4. Redirect to 0x10102 (IALIGN=4) -> misalign_o pulses 1 cycle, misalign_addr_o=0x10102, state=FAULT, pc_valid_o=0. Then trap to 0x30000 -> RUN with pc_o=0x30000.
5. Halt in RUN at 0x10020 -> state=HALT, pc_valid_o=0. Redirect while halted is ignored. resume_i -> RUN at 0x10020. Then assert rst during a stalled fetch -> pc_o=0x10000, state=BOOT.
6. Redirect to 0xFFFFFFFC, then free-run -> pc_plus_o=0x00000000 and pc_o wraps to 0x00000000. With IALIGN=2, a target of 0x10102 is accepted.
